// File: rtl/roce_pkg.sv
// Shared types and descriptor/status field positions for the RoCE request generator.
// Imported by the credit counter and the top-level generator.
package roce_pkg;

   typedef enum logic [2:0] {
      OP_READ  = 3'd0,
      OP_WRITE = 3'd1
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_FINISH
   } state_e;

   localparam int META_OP_LSB    = 0;
   localparam int META_OP_MSB    = 2;
   localparam int META_QPN_LSB   = 3;
   localparam int META_QPN_MSB   = 26;
   localparam int META_LADDR_LSB = 27;
   localparam int META_LADDR_MSB = 74;
   localparam int META_RADDR_LSB = 75;
   localparam int META_RADDR_MSB = 122;
   localparam int META_LEN_LSB   = 123;
   localparam int META_LEN_MSB   = 154;

   localparam int STAT_QPN_LSB  = 0;
   localparam int STAT_QPN_MSB  = 23;
   localparam int STAT_CODE_LSB = 24;
   localparam int STAT_CODE_MSB = 31;

   // Unsupported opcodes degrade to READ so the stack never sees an undefined verb.
   function automatic opcode_e sanitize_opcode(input logic [2:0] raw);
      return (raw == 3'd1) ? OP_WRITE : OP_READ;
   endfunction

endpackage

// File: rtl/roce_credit_cnt.sv
// In-flight request counter: increments on accepted requests, decrements on completions.
// A completion arriving with nothing outstanding is flagged and does not move the count.
module roce_credit_cnt
   import roce_pkg::*;
#(
   parameter int MAX = 8
) (
   input  logic       ap_clk,
   input  logic       areset,
   input  logic       i_inc,
   input  logic       i_dec,
   output logic [7:0] o_count,
   output logic       o_has_credit,
   output logic       o_underflow
);

   logic [7:0] r_count;
   logic       w_dec_ok;

   assign w_dec_ok     = i_dec && (r_count != 8'd0);
   assign o_underflow  = i_dec && (r_count == 8'd0);
   assign o_has_credit = (r_count < 8'(MAX));
   assign o_count      = r_count;

   always_ff @(posedge ap_clk) begin
      if (areset) begin
         r_count <= 8'd0;
      end else begin
         case ({i_inc, w_dec_ok})
            2'b10:   r_count <= r_count + 8'd1;
            2'b01:   r_count <= r_count - 8'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/roce_traffic_gen.sv
// RDMA READ/WRITE request generator for the RoCE tx_meta stream: round-robin over
// NUM_QP QPNs, auto-incrementing addresses, credit-limited, counts completions/errors.
module roce_traffic_gen
   import roce_pkg::*;
#(
   parameter int META_W          = 256,
   parameter int STATUS_W        = 64,
   parameter int NUM_QP          = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                  ap_clk,
   input  logic                  areset,
   input  logic                  start,
   input  logic [2:0]            cfg_opcode,
   input  logic [23:0]           cfg_qpn_base,
   input  logic [4:0]            cfg_len_log2,
   input  logic [31:0]           cfg_num_reqs,
   input  logic [47:0]           cfg_raddr,
   output logic                  m_axis_tx_meta_tvalid,
   input  logic                  m_axis_tx_meta_tready,
   output logic [META_W-1:0]     m_axis_tx_meta_tdata,
   output logic [META_W/8-1:0]   m_axis_tx_meta_tkeep,
   output logic                  m_axis_tx_meta_tlast,
   input  logic                  s_axis_tx_status_tvalid,
   output logic                  s_axis_tx_status_tready,
   input  logic [STATUS_W-1:0]   s_axis_tx_status_tdata,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           stat_issued,
   output logic [31:0]           stat_completed,
   output logic [31:0]           stat_errors
);

   localparam int QP_W = (NUM_QP > 1) ? $clog2(NUM_QP) : 1;

   state_e           r_state;
   state_e           w_state_next;
   opcode_e          r_opcode;
   logic [23:0]      r_qpn_base;
   logic [31:0]      r_len;
   logic [31:0]      r_num_reqs;
   logic [47:0]      r_raddr;
   logic [47:0]      r_offset;
   logic [QP_W-1:0]  r_qp_idx;
   logic [31:0]      r_issued;
   logic [31:0]      r_completed;
   logic [31:0]      r_errors;

   logic             w_tvalid;
   logic             w_hs;
   logic             w_busy;
   logic             w_done;
   logic             w_start_acc;
   logic             w_drained;
   logic             w_status_beat;
   logic             w_code_err;
   logic [7:0]       w_count;
   logic             w_has_credit;
   logic             w_underflow;
   logic [META_W-1:0] w_meta;
   logic             w_unused_status;

   assign w_status_beat   = s_axis_tx_status_tvalid;
   assign w_code_err      = |s_axis_tx_status_tdata[STAT_CODE_MSB:STAT_CODE_LSB];
   assign w_unused_status = ^s_axis_tx_status_tdata;
   assign w_hs            = w_tvalid && m_axis_tx_meta_tready;
   // Looks at the post-edge count so done lands one cycle after the last completion.
   assign w_drained       = (w_count == 8'd0) || ((w_count == 8'd1) && w_status_beat);

   roce_credit_cnt #(
      .MAX (MAX_OUTSTANDING)
   ) u_credit (
      .ap_clk       (ap_clk),
      .areset       (areset),
      .i_inc        (w_hs),
      .i_dec        (w_status_beat),
      .o_count      (w_count),
      .o_has_credit (w_has_credit),
      .o_underflow  (w_underflow)
   );

   always_comb begin
      w_state_next = r_state;
      w_tvalid     = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      w_start_acc  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_start_acc  = 1'b1;
               w_state_next = (cfg_num_reqs == 32'd0) ? ST_FINISH : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_busy   = 1'b1;
            w_tvalid = w_has_credit;
            if (w_tvalid && m_axis_tx_meta_tready && (r_issued == r_num_reqs - 32'd1))
               w_state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            w_busy = 1'b1;
            if (w_drained)
               w_state_next = ST_FINISH;
         end
         ST_FINISH: begin
            w_done       = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Descriptor fields only change on a handshake, so tdata is stable while stalled.
   always_comb begin
      w_meta = '0;
      if (w_tvalid) begin
         w_meta[META_OP_MSB:META_OP_LSB]       = r_opcode;
         w_meta[META_QPN_MSB:META_QPN_LSB]     = r_qpn_base + 24'(r_qp_idx);
         w_meta[META_LADDR_MSB:META_LADDR_LSB] = r_offset;
         w_meta[META_RADDR_MSB:META_RADDR_LSB] = r_raddr + r_offset;
         w_meta[META_LEN_MSB:META_LEN_LSB]     = r_len;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (areset) begin
         r_state     <= ST_IDLE;
         r_opcode    <= OP_READ;
         r_qpn_base  <= 24'd0;
         r_len       <= 32'd0;
         r_num_reqs  <= 32'd0;
         r_raddr     <= 48'd0;
         r_offset    <= 48'd0;
         r_qp_idx    <= '0;
         r_issued    <= 32'd0;
         r_completed <= 32'd0;
         r_errors    <= 32'd0;
      end else begin
         r_state <= w_state_next;
         if (w_start_acc) begin
            r_opcode    <= sanitize_opcode(cfg_opcode);
            r_qpn_base  <= cfg_qpn_base;
            r_len       <= 32'd1 << cfg_len_log2;
            r_num_reqs  <= cfg_num_reqs;
            r_raddr     <= cfg_raddr;
            r_offset    <= 48'd0;
            r_qp_idx    <= '0;
            r_issued    <= 32'd0;
            r_completed <= 32'd0;
            r_errors    <= 32'd0;
         end else begin
            if (w_hs) begin
               r_issued <= r_issued + 32'd1;
               r_offset <= r_offset + 48'(r_len);
               r_qp_idx <= (r_qp_idx == QP_W'(NUM_QP - 1)) ? '0 : r_qp_idx + QP_W'(1);
            end
            if (w_status_beat) begin
               r_completed <= r_completed + 32'd1;
               r_errors    <= r_errors + 32'(w_code_err) + 32'(w_underflow);
            end
         end
      end
   end

   assign m_axis_tx_meta_tvalid   = w_tvalid;
   assign m_axis_tx_meta_tdata    = w_meta;
   assign m_axis_tx_meta_tkeep    = '1;
   assign m_axis_tx_meta_tlast    = 1'b1;
   assign s_axis_tx_status_tready = 1'b1;
   assign busy                    = w_busy;
   assign done                    = w_done;
   assign stat_issued             = r_issued;
   assign stat_completed          = r_completed;
   assign stat_errors             = r_errors;

endmodule

// File: doc/roce_traffic_gen.md
Name: roce_traffic_gen

Overview:
- Parametrised RDMA request generator driving the RoCE stack's tx_meta stream; successor to the single-QP, time-boxed read role.
- Issues a programmed number of READ or WRITE requests, round-robin over NUM_QP consecutive QPNs, at power-of-two length with auto-incrementing addresses.
- Limits in-flight requests with a credit counter fed by s_axis_tx_status completions; finishes only after every request has completed.
- Reports issued/completed/error counts.

Parameters:
META_W, 256, tx_meta tdata width (>=155)
STATUS_W, 64, tx_status tdata width (>=32)
NUM_QP, 4, number of QPNs cycled, 1..256
MAX_OUTSTANDING, 8, max in-flight requests, 1..255

Ports:
ap_clk  in  1  clock
areset  in  1  synchronous active-high reset
start  in  1  single-cycle start pulse; sampled in IDLE only
cfg_opcode  in  3  0=RDMA READ, 1=RDMA WRITE; others forced to 0
cfg_qpn_base  in  24  first local QPN
cfg_len_log2  in  5  request length = 1<<cfg_len_log2 bytes
cfg_num_reqs  in  32  total requests to issue
cfg_raddr  in  48  remote base address
m_axis_tx_meta_tvalid  out  1  request valid
m_axis_tx_meta_tready  in  1  request accept
m_axis_tx_meta_tdata  out  META_W  request descriptor
m_axis_tx_meta_tkeep  out  META_W/8  constant all-ones
m_axis_tx_meta_tlast  out  1  constant 1
s_axis_tx_status_tvalid  in  1  completion valid
s_axis_tx_status_tready  out  1  constant 1
s_axis_tx_status_tdata  in  STATUS_W  [23:0] QPN, [31:24] code (0 = OK)
busy  out  1  high from start until done
done  out  1  one-cycle pulse at completion
stat_issued  out  32  requests accepted by stack
stat_completed  out  32  status beats received
stat_errors  out  32  nonzero codes plus unexpected completions

Behaviour:
- Reset: tvalid=0, tdata=0, busy=0, done=0, all stats=0, outstanding=0, offset=0, qp_idx=0, state IDLE.
- Config is latched on accepted start; later config changes have no effect until the next run.
- Descriptor: [2:0] opcode, [26:3] QPN = cfg_qpn_base+qp_idx (mod 2^24), [74:27] lAddr = offset, [122:75] rAddr = cfg_raddr+offset (mod 2^48), [154:123] len = 1<<cfg_len_log2; upper bits 0.
- States:
  - IDLE: on start, clear stats, offset and qp_idx; busy=1. If cfg_num_reqs==0 go to FINISH, else go to ISSUE.
  - ISSUE: assert tvalid when outstanding<MAX_OUTSTANDING. Hold tdata/tvalid stable until tready. On handshake: issued++, outstanding++, offset+=len (wraps 2^48), qp_idx wraps NUM_QP-1 -> 0. After the last request is accepted, go to DRAIN.
  - DRAIN: tvalid=0. When outstanding==0, go to FINISH.
  - FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Credit rules:
  - Meta handshake and status beat in the same cycle leave outstanding unchanged.
  - The credit check uses the registered count; a slot freed this cycle is usable next cycle.
  - A status beat with outstanding==0 increments stat_errors and leaves outstanding at 0.
  - A nonzero status code increments both stat_errors and stat_completed.
- Status beats are counted in every state, including IDLE, so stray completions appear in stat_errors.
- start outside IDLE is ignored. areset mid-run aborts immediately to reset values; no done pulse.
- Latency: first tvalid 1 cycle after start; done 1 cycle after the final completion.

Decomposition:
- Package roce_pkg:
  - opcode enum (OP_READ=0, OP_WRITE=1)
  - meta field LSB/MSB constants
  - status QPN/code field constants
  - state enum
- Sub-module roce_credit_cnt (MAX parameter): inc/dec inputs; outputs count, has_credit, underflow.

Test Plan:
- READ, qpn_base=0x10, len_log2=12, num_reqs=5, NUM_QP=4, tready=1, status 3 cycles after each accept -> QPNs 10,11,12,13,10; lAddr 0,0x1000..0x4000; issued=completed=5; single done pulse.
- num_reqs=20, MAX_OUTSTANDING=8, status withheld -> exactly 8 handshakes then tvalid=0; releasing one status gives exactly one more handshake.
- tready toggled randomly -> tdata stable while tvalid&&!tready; no duplicated or skipped descriptors.
- Same-cycle accept and status at outstanding=MAX-1 -> count stays MAX-1 and no stall occurs.
- Status code 0x05 on request 2, plus one stray status in IDLE -> stat_errors=2, done still fires after all completions.
- areset asserted mid-DRAIN -> all outputs return to reset values, no done; next start with num_reqs=0 -> done 1 cycle after start, issued=0.
